fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the asynchronous FIFO. It runs entirely in the write clock domain. It shares the FIFO's single write port (w_en / data_in / full) between NUM_REQ producers. Each grant is held for a burst of up to MAX_BURST words or until the owner marks its last word, and the arbiter stalls on full, so no producer ever triggers a FIFO write_error.

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NUM_REQ
//   producers. A grant is held for a burst of up to MAX_BURST words, or
//   until the owner flags its last word or drops its request. The arbiter
//   never writes while the FIFO reports full. There is one idle cycle
//   between bursts.
//
// Ports
//   wclk, wrst   write-domain clock; synchronous active-high reset
//   req          per-producer request (word valid)
//   req_data     producer i word in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     producer i word is the end of its packet
//   fifo_full    FIFO full flag (registered in the FIFO)
//   gnt          one-hot grant (registered)
//   req_ack      producer i word written this cycle (combinational)
//   fifo_w_en    FIFO write enable (combinational)
//   fifo_data    FIFO write data, which is the owner's slice
//   owner        index of the granted producer (registered)
//   busy         high while a burst is in progress (registered)
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic                            fifo_full,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic                            fifo_w_en,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]      owner,
    output logic                            busy
);

    localparam int             OW      = $clog2(NUM_REQ);
    localparam logic [7:0]     CNT_MAX = 8'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_owner_q, last_owner_d;
    logic                 busy_q, busy_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;

    logic [OW-1:0]        sel, cand;
    logic                 sel_vld;
    logic                 ack;
    logic                 burst_end;

    // Round-robin pick. The scan runs from farthest to nearest, so the
    // requester closest after last_owner is assigned last and wins.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = OW'((int'(last_owner_q) + k) % NUM_REQ);
            if (req[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    // A write happens only in BURST, and only when the owner has a word and
    // the FIFO has room. Reset kills the write in the same cycle.
    assign ack       = (state_q == BURST) && req[owner_q] && !fifo_full && !wrst;
    assign fifo_w_en = ack;
    assign fifo_data = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = ack && (owner_q == OW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        busy_d       = busy_q;
        burst_cnt_d  = burst_cnt_q;
        burst_end    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d      = BURST;
                    gnt_d        = '0;
                    gnt_d[sel]   = 1'b1;
                    owner_d      = sel;
                    busy_d       = 1'b1;
                    burst_cnt_d  = '0;
                end
            end
            BURST: begin
                // The last word and the burst limit can coincide. This is
                // still a single end condition, so only one idle cycle follows.
                burst_end = !req[owner_q] ||
                            (ack && (req_last[owner_q] || (burst_cnt_q == CNT_MAX)));
                if (burst_end) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    busy_d       = 1'b0;
                    last_owner_d = owner_q;
                    burst_cnt_d  = '0;
                end else if (ack) begin
                    burst_cnt_d  = burst_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);   // producer 0 wins first
            busy_q       <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            busy_q       <= busy_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. There are two instances on shared inputs:
// u_dut4 (MAX_BURST=4) for most scenarios and the random run, and u_dut16
// (MAX_BURST=16) for the 5-word single-producer packet. Inputs change 1ns
// after the rising edge. Outputs are sampled on the falling edge.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              wclk = 1'b0;
    logic              wrst;
    logic [N-1:0]      req, req_last;
    logic [N*DW-1:0]   req_data;
    logic              fifo_full;

    logic [N-1:0]  g4, a4, g16, a16;
    logic          w4, b4, w16, b16;
    logic [DW-1:0] d4, d16;
    logic [1:0]    o4, o16;

    int n_chk, n_pass;
    int wc[N];

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut4 (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
        .req_last(req_last), .fifo_full(fifo_full), .gnt(g4), .req_ack(a4),
        .fifo_w_en(w4), .fifo_data(d4), .owner(o4), .busy(b4)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(16)) u_dut16 (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
        .req_last(req_last), .fifo_full(fifo_full), .gnt(g16), .req_ack(a16),
        .fifo_w_en(w16), .fifo_data(d16), .owner(o16), .busy(b16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic nx();
        @(posedge wclk);
        #1;
    endtask

    task automatic ne();
        @(negedge wclk);
    endtask

    // Producer p's n-th word: {id, sequence}
    function automatic logic [7:0] wd(input int p, input int n);
        return {p[1:0], n[5:0]};
    endfunction

    task automatic drive_words();
        for (int p = 0; p < N; p++) req_data[p*DW +: DW] = wd(p, wc[p]);
    endtask

    task automatic do_reset();
        wrst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
        for (int p = 0; p < N; p++) wc[p] = 0;
        nx(); nx();
        wrst = 1'b0;
    endtask

    // Reference model state for u_dut4 (random phase)
    logic       m_busy;
    int         m_own, m_cnt, m_last;
    logic       e_wen;
    logic [3:0] e_gnt, e_ack, ack_s, one;

    initial begin
        n_chk = 0; n_pass = 0;
        one = 4'b0001;

        // ---------------- reset state ----------------
        do_reset();
        ne();
        chk("rst_gnt", g4, 0);   chk("rst_busy", b4, 0);  chk("rst_owner", o4, 0);
        chk("rst_wen", w4, 0);   chk("rst_ack", a4, 0);
        chk("rst_gnt16", g16, 0); chk("rst_busy16", b16, 0); chk("rst_owner16", o16, 0);
        nx();

        // ---------------- single producer (MAX_BURST=16) ----------------
        do_reset();
        req = 4'b0100; req_data[2*DW +: DW] = 8'hA0;
        ne();
        chk("sp_pre_gnt", g16, 0); chk("sp_pre_wen", w16, 0);
        nx();
        for (int k = 0; k < 5; k++) begin
            req_data[2*DW +: DW] = 8'hA0 + 8'(k);
            req_last[2] = (k == 4);
            ne();
            chk("sp_gnt", g16, 4'b0100); chk("sp_busy", b16, 1); chk("sp_wen", w16, 1);
            chk("sp_data", d16, 8'hA0 + 8'(k)); chk("sp_ack", a16, 4'b0100);
            nx();
        end
        req = '0; req_last = '0;
        ne();
        chk("sp_end_gnt", g16, 0); chk("sp_end_busy", b16, 0); chk("sp_end_wen", w16, 0);
        nx();

        // ---------------- round-robin, all requesting ----------------
        do_reset();
        req = 4'hF; drive_words();
        ne(); chk("rr_first_idle", b4, 0); nx();
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                drive_words();
                ne();
                chk("rr_owner", o4, b % 4); chk("rr_gnt", g4, one << (b % 4));
                chk("rr_wen", w4, 1); chk("rr_data", d4, wd(b % 4, (b / 4) * 4 + w));
                for (int p = 0; p < N; p++) if (a4[p]) wc[p]++;
                nx();
            end
            drive_words();
            ne(); chk("rr_gap_busy", b4, 0); chk("rr_gap_wen", w4, 0);
            nx();
        end

        // ---------------- full stall mid-burst, producer 1 ----------------
        do_reset();
        req = 4'b0010; drive_words();
        ne(); nx();
        for (int i = 0; i < 7; i++) begin
            fifo_full = (i >= 2 && i <= 4);
            drive_words();
            ne();
            chk("fs_gnt", g4, 4'b0010); chk("fs_wen", w4, {31'b0, !fifo_full});
            chk("fs_ack", a4, fifo_full ? 4'b0000 : 4'b0010);
            if (a4[1]) wc[1]++;
            nx();
        end
        fifo_full = 1'b0; drive_words();
        ne(); chk("fs_end_busy", b4, 0); chk("fs_words", wc[1], 4);
        nx();

        // ---------------- abandon by producer 3 ----------------
        do_reset();
        req = 4'b1000; drive_words();
        ne(); nx();
        for (int w = 0; w < 2; w++) begin
            drive_words();
            ne(); chk("ab_owner", o4, 3); chk("ab_wen", w4, 1);
            if (a4[3]) wc[3]++;
            nx();
        end
        req = 4'b0011; drive_words();
        ne(); chk("ab_drop_wen", w4, 0); chk("ab_drop_ack", a4, 0); nx();
        ne(); chk("ab_idle_busy", b4, 0); chk("ab_words", wc[3], 2); nx();
        ne(); chk("ab_next_gnt", g4, 4'b0001); chk("ab_next_wen", w4, 1); nx();

        // ---------------- last on word MAX_BURST ----------------
        do_reset();
        req = 4'b0001; drive_words();
        ne(); nx();
        for (int w = 0; w < 4; w++) begin
            req_last[0] = (w == 3); drive_words();
            ne(); chk("se_gnt", g4, 4'b0001); chk("se_wen", w4, 1);
            if (a4[0]) wc[0]++;
            nx();
        end
        req_last = '0; drive_words();
        ne(); chk("se_idle_busy", b4, 0); chk("se_idle_wen", w4, 0); nx();
        drive_words();
        ne(); chk("se_regnt", g4, 4'b0001); chk("se_rewen", w4, 1); chk("se_data", d4, wd(0, 4));
        nx();

        // ---------------- reset mid-burst ----------------
        do_reset();
        req = 4'b0001; req_last = 4'b0001; drive_words();
        ne(); nx();
        ne(); chk("rm_w0", w4, 1); if (a4[0]) wc[0]++; nx();
        req = 4'b0100; req_last = '0; drive_words();
        ne(); chk("rm_idle", b4, 0); nx();
        for (int w = 0; w < 3; w++) begin
            wrst = (w == 2); drive_words();
            ne();
            if (w < 2) chk("rm_wen", w4, 1);
            else begin
                chk("rm_rst_wen", w4, 0); chk("rm_rst_ack", a4, 0);
            end
            if (a4[2]) wc[2]++;
            nx();
        end
        wrst = 1'b0; req = 4'b0101; drive_words();
        ne();
        chk("rm_post_gnt", g4, 0); chk("rm_post_busy", b4, 0); chk("rm_post_owner", o4, 0);
        chk("rm_post_wen", w4, 0); chk("rm_post_ack", a4, 0);
        nx();
        ne(); chk("rm_next_owner", o4, 0); chk("rm_next_gnt", g4, 4'b0001); nx();

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_busy = 1'b0; m_own = 0; m_cnt = 0; m_last = N - 1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            ne();
            e_gnt = m_busy ? (one << m_own) : 4'b0000;
            e_wen = m_busy && req[m_own] && !fifo_full && !wrst;
            e_ack = e_wen ? (one << m_own) : 4'b0000;
            chk("rnd_gnt", g4, e_gnt); chk("rnd_busy", b4, m_busy);
            chk("rnd_owner", o4, m_own); chk("rnd_wen", w4, e_wen); chk("rnd_ack", a4, e_ack);
            if (e_wen) chk("rnd_data", d4, wd(m_own, wc[m_own]));
            ack_s = a4;
            // apply the spec rules for this edge
            if (wrst) begin
                m_busy = 1'b0; m_own = 0; m_cnt = 0; m_last = N - 1;
            end else if (!m_busy) begin
                if (req != '0) begin
                    for (int k = N; k >= 1; k--) if (req[(m_last + k) % N]) m_own = (m_last + k) % N;
                    m_busy = 1'b1; m_cnt = 0;
                end
            end else if (!req[m_own]) begin
                m_busy = 1'b0; m_last = m_own;
            end else if (e_wen) begin
                m_cnt++;
                if (req_last[m_own] || m_cnt == 4) begin
                    m_busy = 1'b0; m_last = m_own;
                end
            end
            nx();
            for (int p = 0; p < N; p++) begin
                if (ack_s[p]) begin
                    wc[p]++;
                    req[p] = ($urandom % 4 != 0);
                    req_last[p] = ($urandom % 4 == 0);
                end else if (req[p]) begin
                    if ($urandom % 20 == 0) req[p] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req[p] = 1'b1;
                    req_last[p] = ($urandom % 4 == 0);
                end
            end
            fifo_full = ($urandom % 5 == 0);
            wrst = ($urandom % 64 == 0);
            drive_words();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
